// File: rtl/mc_controller.sv
// Multicycle control FSM for the ARM-subset datapath: sequences fetch/decode/
// execute/memory/writeback, owns the NZCV register and gates writes by condition.
module mc_controller #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemW,
  output logic       IRWrite,
  output logic       RegW,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] ALUControl,
  output logic [3:0] Flags,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_UNKNOWN = 4'd10
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'h4;

  state_t     state, state_nxt;
  logic [3:0] flags_q;
  logic       cond_ex;
  logic       is_cmp;
  logic       is_arith;
  logic       flag_we;
  logic       dp_wb_we;
  logic       flag_n, flag_z, flag_c, flag_v;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;
  assign Flags = flags_q;

  // Condition check always looks at the architectural flags, not the live ALU flags.
  always_comb begin
    cond_ex = 1'b1;
    case (Cond)
      4'h0: cond_ex = flag_z;
      4'h1: cond_ex = ~flag_z;
      4'h2: cond_ex = flag_c;
      4'h3: cond_ex = ~flag_c;
      4'h4: cond_ex = flag_n;
      4'h5: cond_ex = ~flag_n;
      4'h6: cond_ex = flag_v;
      4'h7: cond_ex = ~flag_v;
      4'h8: cond_ex = flag_c & ~flag_z;
      4'h9: cond_ex = ~flag_c | flag_z;
      4'hA: cond_ex = (flag_n == flag_v);
      4'hB: cond_ex = (flag_n != flag_v);
      4'hC: cond_ex = ~flag_z & (flag_n == flag_v);
      4'hD: cond_ex = flag_z | (flag_n != flag_v);
      default: cond_ex = 1'b1;
    endcase
  end

  // TST/TEQ/CMP/CMN only set flags; they never write the register file.
  assign is_cmp = (Funct[4:3] == 2'b10);

  always_comb begin
    is_arith = 1'b0;
    case (Funct[4:1])
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB: is_arith = 1'b1;
      default: is_arith = 1'b0;
    endcase
  end

  assign flag_we  = ((state == S_EXECR) || (state == S_EXECI)) && Funct[0] && cond_ex;
  assign dp_wb_we = cond_ex & ~is_cmp;

  // NOTE: state and flag registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      flags_q <= RESET_FLAGS;
    end else begin
      state <= state_nxt;
      if (flag_we) begin
        flags_q[3:2] <= ALUFlags[3:2];
        if (is_arith) flags_q[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // NOTE: every output and the next state get a default before the case, so no
  // path through this block leaves a signal unassigned (no inferred latches).
  always_comb begin
    state_nxt  = S_FETCH;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemW       = 1'b0;
    IRWrite    = 1'b0;
    RegW       = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    ALUControl = ALU_ADD;
    Illegal    = 1'b0;

    case (state)
      S_FETCH: begin
        AdrSrc    = 1'b0;
        IRWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        RegSrc  = {(Op == 2'b01), (Op == 2'b10)};
        ImmSrc  = (Op == 2'b11) ? 2'b00 : Op;
        case (Op)
          2'b00:   state_nxt = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_nxt = S_MEMADR;
          2'b10:   state_nxt = S_BRANCH;
          default: state_nxt = S_UNKNOWN;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b01;
        state_nxt = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc    = 1'b1;
        state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = cond_ex;
        PCWrite   = cond_ex & (Rd == 4'hF);
        state_nxt = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc    = 1'b1;
        MemW      = cond_ex;
        state_nxt = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = Funct[4:1];
        state_nxt  = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b01;
        ALUControl = Funct[4:1];
        state_nxt  = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = 2'b00;
        RegW      = dp_wb_we;
        PCWrite   = dp_wb_we & (Rd == 4'hF);
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b01;
        ImmSrc    = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = cond_ex;
        state_nxt = S_FETCH;
      end
      S_UNKNOWN: begin
        Illegal   = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios plus random
// instructions checked against an instruction-level reference model.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] alu_flags;
  logic       pc_write, adr_src, mem_w, ir_write, reg_w, alu_src_a, illegal;
  logic [1:0] result_src, alu_src_b, imm_src, reg_src;
  logic [3:0] alu_control, flags;

  int n_tests = 0;
  int n_fail  = 0;

  mc_controller #(.RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .reset(rst_n),
    .Cond(cond), .Op(op), .Funct(funct), .Rd(rd), .ALUFlags(alu_flags),
    .PCWrite(pc_write), .AdrSrc(adr_src), .MemW(mem_w), .IRWrite(ir_write),
    .RegW(reg_w), .ResultSrc(result_src), .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b),
    .ImmSrc(imm_src), .RegSrc(reg_src), .ALUControl(alu_control), .Flags(flags),
    .Illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference model state and per-instruction expectations.
  logic [3:0] m_flags;
  int e_cycles, e_regw, e_memw, e_pcw, e_ill;

  // Observations collected while an instruction runs.
  int o_cycles, o_regw, o_memw, o_pcw, o_ill;
  logic [3:0] o_aluc  [12];
  logic [1:0] o_ress  [12];
  logic [1:0] o_imms  [12];
  logic [1:0] o_regsrc[12];
  logic       o_adr   [12];
  logic       o_memw_c[12];
  logic       o_ill_c [12];

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n = f[3];
    bit z = f[2];
    bit cc = f[1];
    bit v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cc;
      4'h3: return !cc;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cc && !z;
      4'h9: return !cc || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // Instruction-level prediction: cycle count, number of architectural writes, new flags.
  task automatic predict(input logic [3:0] c, input logic [1:0] o, input logic [5:0] fn,
                         input logic [3:0] d, input logic [3:0] af);
    bit ok = cond_holds(c, m_flags);
    e_regw = 0; e_memw = 0; e_pcw = 0; e_ill = 0;
    case (o)
      2'd0: begin
        e_cycles = 4;
        if (ok && fn[0]) begin
          m_flags[3:2] = af[3:2];
          if (fn[4:1] inside {[4'h2:4'h7], 4'hA, 4'hB}) m_flags[1:0] = af[1:0];
        end
        e_regw = (cond_holds(c, m_flags) && fn[4:3] != 2'b10) ? 1 : 0;
        e_pcw  = (e_regw == 1 && d == 4'hF) ? 1 : 0;
      end
      2'd1: begin
        e_cycles = fn[0] ? 5 : 4;
        e_regw   = (fn[0] && ok) ? 1 : 0;
        e_memw   = (!fn[0] && ok) ? 1 : 0;
        e_pcw    = (e_regw == 1 && d == 4'hF) ? 1 : 0;
      end
      2'd2: begin
        e_cycles = 3;
        e_pcw    = ok ? 1 : 0;
      end
      default: begin
        e_cycles = 3;
        e_ill    = 1;
      end
    endcase
  endtask

  // Drives one instruction starting in FETCH; returns at the next FETCH (bounded).
  task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] fn,
                           input logic [3:0] d, input logic [3:0] af);
    cond = c; op = o; funct = fn; rd = d; alu_flags = af;
    #1;
    o_cycles = 0; o_regw = 0; o_memw = 0; o_pcw = 0; o_ill = 0;
    do begin
      o_aluc[o_cycles]   = alu_control;
      o_ress[o_cycles]   = result_src;
      o_imms[o_cycles]   = imm_src;
      o_regsrc[o_cycles] = reg_src;
      o_adr[o_cycles]    = adr_src;
      o_memw_c[o_cycles] = mem_w;
      o_ill_c[o_cycles]  = illegal;
      o_regw += int'(reg_w);
      o_memw += int'(mem_w);
      o_ill  += int'(illegal);
      if (o_cycles > 0) o_pcw += int'(pc_write);
      o_cycles++;
      @(negedge clk); #1;
    end while (!ir_write && o_cycles < 12);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", flags); end
    n_tests++;
    if ({ir_write, pc_write, alu_src_a, alu_src_b, result_src, adr_src} !== 8'b1_1_1_10_10_0) begin
      n_fail++; $display("FAIL reset_fetch_ctrl: got ir=%b pc=%b a=%b b=%b res=%b adr=%b",
                         ir_write, pc_write, alu_src_a, alu_src_b, result_src, adr_src);
    end
    n_tests++;
    if ({reg_w, mem_w, illegal, alu_control} !== 7'b000_0100) begin
      n_fail++; $display("FAIL reset_idle: got regw=%b memw=%b ill=%b aluc=%h", reg_w, mem_w, illegal, alu_control);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_flags = 4'b0000;
  endtask

  task automatic test_adds;
    predict(4'hE, 2'b00, 6'b101001, 4'h3, 4'b0110);
    run_instr(4'hE, 2'b00, 6'b101001, 4'h3, 4'b0110);
    n_tests++;
    if (o_cycles !== 4) begin n_fail++; $display("FAIL adds_cycles: got %0d want 4", o_cycles); end
    n_tests++;
    if (o_regw !== 1) begin n_fail++; $display("FAIL adds_regw: got %0d want 1", o_regw); end
    n_tests++;
    if (flags !== 4'b0110 || flags !== m_flags) begin
      n_fail++; $display("FAIL adds_flags: got %b want %b", flags, m_flags);
    end
    n_tests++;
    if (o_aluc[2] !== 4'h4) begin n_fail++; $display("FAIL adds_aluc: got %h want 4", o_aluc[2]); end
  endtask

  task automatic test_reset_mid;
    int guard;
    cond = 4'hE; op = 2'b01; funct = 6'b011001; rd = 4'h2; alu_flags = 4'($urandom);
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (adr_src !== 1'b1) begin n_fail++; $display("FAIL mid_memrd_adr: got %b want 1", adr_src); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ir_write, pc_write, adr_src, flags} !== 7'b1_1_0_0000) begin
      n_fail++; $display("FAIL mid_reset_abort: got ir=%b pc=%b adr=%b flags=%b", ir_write, pc_write, adr_src, flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_flags = 4'b0000;
    #1;
    n_tests++;
    if ({ir_write, pc_write} !== 2'b11) begin
      n_fail++; $display("FAIL mid_first_fetch: got ir=%b pc=%b want 11", ir_write, pc_write);
    end
    @(negedge clk); #1;
    n_tests++;
    if ({ir_write, pc_write, alu_src_b} !== 4'b00_10) begin
      n_fail++; $display("FAIL mid_then_decode: got ir=%b pc=%b b=%b", ir_write, pc_write, alu_src_b);
    end
    guard = 0;
    while (!ir_write && guard < 12) begin @(negedge clk); #1; guard++; end
    n_tests++;
    if (ir_write !== 1'b1) begin n_fail++; $display("FAIL mid_realign_timeout: got ir=%b want 1", ir_write); end
  endtask

  task automatic test_cmp_branch;
    predict(4'hE, 2'b00, 6'b010101, 4'h0, 4'b0100);
    run_instr(4'hE, 2'b00, 6'b010101, 4'h0, 4'b0100);
    n_tests++;
    if (flags !== 4'b0100) begin n_fail++; $display("FAIL cmp_flags: got %b want 0100", flags); end
    n_tests++;
    if (o_regw !== 0 || o_aluc[2] !== 4'hA) begin
      n_fail++; $display("FAIL cmp_regw_aluc: got regw=%0d aluc=%h want 0 A", o_regw, o_aluc[2]);
    end
    predict(4'h0, 2'b10, 6'b100000, 4'h0, 4'b0000);
    run_instr(4'h0, 2'b10, 6'b100000, 4'h0, 4'b0000);
    n_tests++;
    if (o_pcw !== 1 || o_cycles !== 3) begin
      n_fail++; $display("FAIL beq_taken: got pcw=%0d cycles=%0d want 1 3", o_pcw, o_cycles);
    end
    n_tests++;
    if (o_imms[2] !== 2'b10 || o_ress[2] !== 2'b10 || o_regsrc[1] !== 2'b01) begin
      n_fail++; $display("FAIL branch_ctrl: got imm=%b res=%b regsrc=%b", o_imms[2], o_ress[2], o_regsrc[1]);
    end
    predict(4'h1, 2'b10, 6'b100000, 4'h0, 4'b0000);
    run_instr(4'h1, 2'b10, 6'b100000, 4'h0, 4'b0000);
    n_tests++;
    if (o_pcw !== 0 || o_cycles !== 3) begin
      n_fail++; $display("FAIL bne_not_taken: got pcw=%0d cycles=%0d want 0 3", o_pcw, o_cycles);
    end
  endtask

  task automatic test_ldr_pc;
    predict(4'hE, 2'b01, 6'b011001, 4'hF, 4'b0000);
    run_instr(4'hE, 2'b01, 6'b011001, 4'hF, 4'b0000);
    n_tests++;
    if (o_cycles !== 5) begin n_fail++; $display("FAIL ldr_cycles: got %0d want 5", o_cycles); end
    n_tests++;
    if (o_ress[4] !== 2'b01 || o_regw !== 1 || o_pcw !== 1) begin
      n_fail++; $display("FAIL ldr_pc_wb: got res=%b regw=%0d pcw=%0d want 01 1 1", o_ress[4], o_regw, o_pcw);
    end
    n_tests++;
    if (o_adr[3] !== 1'b1 || o_imms[1] !== 2'b01 || o_regsrc[1] !== 2'b10) begin
      n_fail++; $display("FAIL ldr_path: got adr=%b imm=%b regsrc=%b", o_adr[3], o_imms[1], o_regsrc[1]);
    end
  endtask

  task automatic test_strne;
    predict(4'h1, 2'b01, 6'b011000, 4'h5, 4'b0000);
    run_instr(4'h1, 2'b01, 6'b011000, 4'h5, 4'b0000);
    n_tests++;
    if (o_memw !== 0 || o_cycles !== 4) begin
      n_fail++; $display("FAIL strne_suppressed: got memw=%0d cycles=%0d want 0 4", o_memw, o_cycles);
    end
    predict(4'hE, 2'b00, 6'b001001, 4'h1, 4'b0000);
    run_instr(4'hE, 2'b00, 6'b001001, 4'h1, 4'b0000);
    n_tests++;
    if (flags !== 4'b0000) begin n_fail++; $display("FAIL adds_clear_flags: got %b want 0000", flags); end
    predict(4'h1, 2'b01, 6'b011000, 4'h5, 4'b0000);
    run_instr(4'h1, 2'b01, 6'b011000, 4'h5, 4'b0000);
    n_tests++;
    if (o_memw !== 1 || o_memw_c[3] !== 1'b1 || o_cycles !== 4) begin
      n_fail++; $display("FAIL strne_write: got memw=%0d memwr=%b cycles=%0d want 1 1 4", o_memw, o_memw_c[3], o_cycles);
    end
  endtask

  task automatic test_ands_illegal;
    predict(4'hE, 2'b00, 6'b000101, 4'h2, 4'b0011);
    run_instr(4'hE, 2'b00, 6'b000101, 4'h2, 4'b0011);
    n_tests++;
    if (flags !== 4'b0011) begin n_fail++; $display("FAIL subs_flags: got %b want 0011", flags); end
    predict(4'hE, 2'b00, 6'b000001, 4'h2, 4'b1000);
    run_instr(4'hE, 2'b00, 6'b000001, 4'h2, 4'b1000);
    n_tests++;
    if (flags !== 4'b1011) begin n_fail++; $display("FAIL ands_hold_cv: got %b want 1011", flags); end
    predict(4'hE, 2'b11, 6'b000000, 4'h0, 4'b0000);
    run_instr(4'hE, 2'b11, 6'b000000, 4'h0, 4'b0000);
    n_tests++;
    if (o_ill !== 1 || o_ill_c[2] !== 1'b1 || o_cycles !== 3) begin
      n_fail++; $display("FAIL illegal_pulse: got ill=%0d at2=%b cycles=%0d want 1 1 3", o_ill, o_ill_c[2], o_cycles);
    end
    n_tests++;
    if (o_regw !== 0 || o_memw !== 0 || o_pcw !== 0) begin
      n_fail++; $display("FAIL illegal_no_writes: got regw=%0d memw=%0d pcw=%0d", o_regw, o_memw, o_pcw);
    end
  endtask

  task automatic test_random;
    logic [3:0] c, d, af;
    logic [1:0] o;
    logic [5:0] fn;
    for (int i = 0; i < 80; i++) begin
      c  = 4'($urandom);
      o  = 2'($urandom);
      fn = 6'($urandom);
      d  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      af = 4'($urandom);
      predict(c, o, fn, d, af);
      run_instr(c, o, fn, d, af);
      n_tests++;
      if (o_cycles !== e_cycles || o_regw !== e_regw || o_memw !== e_memw || o_pcw !== e_pcw || o_ill !== e_ill) begin
        n_fail++;
        $display("FAIL rand_%0d c=%h op=%b f=%b rd=%h: got cyc=%0d rw=%0d mw=%0d pcw=%0d ill=%0d want %0d %0d %0d %0d %0d",
                 i, c, o, fn, d, o_cycles, o_regw, o_memw, o_pcw, o_ill, e_cycles, e_regw, e_memw, e_pcw, e_ill);
      end
      n_tests++;
      if (flags !== m_flags) begin
        n_fail++; $display("FAIL rand_flags_%0d: got %b want %b", i, flags, m_flags);
      end
      if (o == 2'b00) begin
        n_tests++;
        if (o_aluc[2] !== fn[4:1]) begin
          n_fail++; $display("FAIL rand_aluc_%0d: got %h want %h", i, o_aluc[2], fn[4:1]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; cond = 4'hE; op = 2'b00; funct = 6'd0; rd = 4'd0; alu_flags = 4'd0;
    m_flags = 4'b0000;
    test_reset;
    test_adds;
    test_reset_mid;
    test_cmp_branch;
    test_ldr_pc;
    test_strne;
    test_ands_illegal;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
